// File: rtl/axi_lite_master.sv
// AXI-Lite master for the APB-to-AXI-Lite bridge: runs one AW/W/B or AR/R transaction
// per start request and returns read data, response code and a completion pulse.
module axi_lite_master #(
   parameter int unsigned AW_APB = 32,
   parameter int unsigned DW_APB = 32
) (
   input  logic                  apb_clk,
   input  logic                  sys_aresetn,
   input  logic                  start_write,
   input  logic                  start_read,
   input  logic [AW_APB-1:0]     address,
   input  logic [DW_APB-1:0]     write_data,
   input  logic [DW_APB/8-1:0]   be,
   input  logic [2:0]            prot,
   output logic [DW_APB-1:0]     read_data,
   output logic                  read_data_valid,
   output logic                  done_write,
   output logic [1:0]            resp,
   output logic                  busy,
   output logic [AW_APB-1:0]     m_axi_awaddr,
   output logic [2:0]            m_axi_awprot,
   output logic                  m_axi_awvalid,
   input  logic                  m_axi_awready,
   output logic [DW_APB-1:0]     m_axi_wdata,
   output logic [DW_APB/8-1:0]   m_axi_wstrb,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,
   input  logic [1:0]            m_axi_bresp,
   input  logic                  m_axi_bvalid,
   output logic                  m_axi_bready,
   output logic [AW_APB-1:0]     m_axi_araddr,
   output logic [2:0]            m_axi_arprot,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic [DW_APB-1:0]     m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready
);

   typedef enum logic [2:0] {StIdle, StWrReq, StWrResp, StRdReq, StRdResp} state_e;

   state_e              state_q, state_d;
   logic [AW_APB-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
   logic [2:0]          awprot_q, awprot_d, arprot_q, arprot_d;
   logic [DW_APB-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
   logic [DW_APB/8-1:0] wstrb_q, wstrb_d;
   logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
   logic                arvalid_q, arvalid_d, rready_q, rready_d;
   logic                aw_done_q, aw_done_d, w_done_q, w_done_d;
   logic                rdv_q, rdv_d, done_q, done_d, busy_q, busy_d;
   logic [1:0]          resp_q, resp_d;

   always_comb begin
      state_d   = state_q;
      awaddr_d  = awaddr_q;
      awprot_d  = awprot_q;
      araddr_d  = araddr_q;
      arprot_d  = arprot_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      rdata_d   = rdata_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      bready_d  = bready_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      resp_d    = resp_q;
      busy_d    = busy_q;
      rdv_d     = 1'b0;
      done_d    = 1'b0;
      case (state_q)
         StIdle: begin
            // Write has priority; a simultaneous read request is dropped.
            if (start_write) begin
               awaddr_d  = address;
               awprot_d  = prot;
               wdata_d   = write_data;
               wstrb_d   = be;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               busy_d    = 1'b1;
               state_d   = StWrReq;
            end else if (start_read) begin
               araddr_d  = address;
               arprot_d  = prot;
               arvalid_d = 1'b1;
               busy_d    = 1'b1;
               state_d   = StRdReq;
            end
         end
         StWrReq: begin
            aw_done_d = aw_done_q | (awvalid_q & m_axi_awready);
            w_done_d  = w_done_q | (wvalid_q & m_axi_wready);
            if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
            if (wvalid_q && m_axi_wready) wvalid_d = 1'b0;
            if (aw_done_d && w_done_d) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               bready_d  = 1'b1;
               state_d   = StWrResp;
            end
         end
         StWrResp: begin
            if (m_axi_bvalid && bready_q) begin
               resp_d   = m_axi_bresp;
               done_d   = 1'b1;
               bready_d = 1'b0;
               busy_d   = 1'b0;
               state_d  = StIdle;
            end
         end
         StRdReq: begin
            if (arvalid_q && m_axi_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = StRdResp;
            end
         end
         StRdResp: begin
            if (m_axi_rvalid && rready_q) begin
               rdata_d  = m_axi_rdata;
               resp_d   = m_axi_rresp;
               rdv_d    = 1'b1;
               rready_d = 1'b0;
               busy_d   = 1'b0;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge apb_clk or negedge sys_aresetn) begin
      if (!sys_aresetn) begin
         state_q   <= StIdle;
         awaddr_q  <= '0;
         awprot_q  <= '0;
         araddr_q  <= '0;
         arprot_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rdata_q   <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         resp_q    <= '0;
         busy_q    <= 1'b0;
         rdv_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         awaddr_q  <= awaddr_d;
         awprot_q  <= awprot_d;
         araddr_q  <= araddr_d;
         arprot_q  <= arprot_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         rdata_q   <= rdata_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         resp_q    <= resp_d;
         busy_q    <= busy_d;
         rdv_q     <= rdv_d;
         done_q    <= done_d;
      end
   end

   assign read_data       = rdata_q;
   assign read_data_valid = rdv_q;
   assign done_write      = done_q;
   assign resp            = resp_q;
   assign busy            = busy_q;
   assign m_axi_awaddr    = awaddr_q;
   assign m_axi_awprot    = awprot_q;
   assign m_axi_awvalid   = awvalid_q;
   assign m_axi_wdata     = wdata_q;
   assign m_axi_wstrb     = wstrb_q;
   assign m_axi_wvalid    = wvalid_q;
   assign m_axi_bready    = bready_q;
   assign m_axi_araddr    = araddr_q;
   assign m_axi_arprot    = arprot_q;
   assign m_axi_arvalid   = arvalid_q;
   assign m_axi_rready    = rready_q;

endmodule
